// File: rtl/oam_dma.sv
// OAM DMA initiator: a CPU store to REG_ADDR latches a source page, then LENGTH
// bytes are copied from {page, 00..} to DEST_BASE.. using the DMA side of the bus.
module oam_dma #(
  parameter logic [15:0] REG_ADDR  = 16'hFF46,
  parameter logic [15:0] DEST_BASE = 16'hFE00,
  parameter int unsigned LENGTH    = 160
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] dma_address,
  input  logic [7:0]  dma_indata,
  output logic [7:0]  dma_outdata,
  output logic        dma_load,
  output logic        dma_store,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RD,
    S_WAIT1,
    S_WAIT2,
    S_WR
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;
  logic [7:0]  r_outdata;
  logic [1:0]  r_dly;
  logic        w_reg_hit;
  logic        w_reg_wr;
  logic        w_reg_rd;
  logic [7:0]  w_src_page;

  assign w_reg_hit = (address == REG_ADDR);
  assign w_reg_wr  = store && w_reg_hit;
  assign w_reg_rd  = load && w_reg_hit;
  // Pages E0..FF alias the C0..DF work RAM through echo RAM.
  assign w_src_page = (r_page[7:5] == 3'b111) ? (r_page & 8'hDF) : r_page;
  assign outdata    = r_outdata;

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_page    <= 8'hFF;
      r_idx     <= '0;
      r_dly     <= '0;
      r_data    <= '0;
      r_outdata <= '0;
    end else begin
      r_outdata <= w_reg_rd ? r_page : '0;
      if (r_state == S_WAIT2) begin
        r_data <= dma_indata;
      end
      if (w_reg_wr) begin
        r_page <= indata;
        r_idx  <= '0;
        r_dly  <= '0;
      end else begin
        if (r_state == S_START) begin
          r_dly <= r_dly + 2'd1;
        end
        if (r_state == S_WR && r_idx != LAST_IDX) begin
          r_idx <= r_idx + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    dma_active  = 1'b1;
    dma_load    = 1'b0;
    dma_store   = 1'b0;
    dma_address = '0;
    dma_outdata = '0;
    case (r_state)
      S_IDLE: begin
        dma_active = 1'b0;
      end
      S_START: begin
        if (r_dly == 2'd3) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        dma_load    = 1'b1;
        dma_address = {w_src_page, r_idx};
        w_next      = S_WAIT1;
      end
      S_WAIT1: begin
        w_next = S_WAIT2;
      end
      S_WAIT2: begin
        w_next = S_WR;
      end
      S_WR: begin
        // A restart in this cycle abandons the byte, so its store never appears.
        if (!w_reg_wr) begin
          dma_store   = 1'b1;
          dma_address = DEST_BASE + {8'h00, r_idx};
          dma_outdata = r_data;
        end
        w_next = (r_idx == LAST_IDX) ? S_IDLE : S_RD;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_reg_wr) begin
      w_next = S_START;
    end
  end

endmodule
